fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 40 ++++
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue that sits between the
// fetch stage and decode: queue depth, instruction/PC width, the NOP word
// presented when the queue is empty, and the push/pop operation encoding.
package fetch_queue_pkg;

    // Default number of queue entries (power of two, at least 2).
    localparam int FQ_DEPTH = 4;

    // Pointer width matching FQ_DEPTH.
    localparam int FQ_AW = 2;

    // Width of an instruction word and of a PC+4 value.
    localparam int FQ_XLEN = 32;

    // Word shown to decode when no entry is valid.
    localparam logic [FQ_XLEN-1:0] FQ_NOP = 32'h0000_0000;

    // What the queue does at the next edge, ignoring flush.
    typedef enum logic [1:0] {
        FQ_OP_IDLE = 2'b00,
        FQ_OP_PUSH = 2'b01,
        FQ_OP_POP  = 2'b10,
        FQ_OP_BOTH = 2'b11
    } fq_op_e;

    // Fold the individual push/pop handshakes into one operation code so the
    // pointer/occupancy update can be a single case statement.
    function automatic fq_op_e fq_decode(input logic push, input logic pop);
        fq_op_e op;
        case ({pop, push})
            2'b00:   op = FQ_OP_IDLE;
            2'b01:   op = FQ_OP_PUSH;
            2'b10:   op = FQ_OP_POP;
            2'b11:   op = FQ_OP_BOTH;
            default: op = FQ_OP_IDLE;
        endcase
        return op;
    endfunction

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a small circular buffer decoupling the fetch stage
// from decode. Entries are {instruction, PC+4}. The head is read straight out
// of the register array, so an entry pushed into an empty queue reaches decode
// one cycle after the push and never combinationally in the push cycle.
// in_ready depends only on occupancy, never on out_ready, so a full queue
// cannot accept a new entry even while decode drains the head.
// Flush (branch/jump redirect) empties the queue by clearing the pointers and
// occupancy; the array contents are left alone because they become
// unreachable.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = FQ_AW
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [31:0]        ins_in,
    input  logic [31:0]        pc4_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [31:0]        out_ins,
    output logic [31:0]        out_pc4,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               Flush,
    output logic [AW:0]        count
);

    // Occupancy value that means "full", sized to the counter.
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Architectural state: pointers wrap naturally at AW bits (DEPTH = 2**AW).
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    // Storage array; written only on an accepted push, never reset.
    logic [FQ_XLEN-1:0] ins_mem_q [DEPTH];
    logic [FQ_XLEN-1:0] pc4_mem_q [DEPTH];

    // Handshake and control decode.
    logic   in_ready_s;
    logic   out_valid_s;
    logic   push_s;
    logic   pop_s;
    logic   wr_en_s;
    fq_op_e op_s;

    assign in_ready_s  = (count_q < CNT_FULL);
    assign out_valid_s = (count_q != CNT_ZERO);
    assign push_s      = in_valid & in_ready_s;
    assign pop_s       = out_valid_s & out_ready;
    assign op_s        = fq_decode(push_s, pop_s);

    // A flush in the same cycle drops the incoming entry entirely.
    assign wr_en_s     = push_s & ~Flush;

    // Next pointers and occupancy; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            case (op_s)
                FQ_OP_IDLE: begin
                    count_d = count_q;
                end
                FQ_OP_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    count_d  = count_q + CNT_ONE;
                end
                FQ_OP_POP: begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    count_d  = count_q - CNT_ONE;
                end
                FQ_OP_BOTH: begin
                    // Push and pop together: occupancy unchanged.
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    count_d  = count_q;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously by Reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write on an accepted, non-flushed push.
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            ins_mem_q[wr_ptr_q] <= ins_in;
            pc4_mem_q[wr_ptr_q] <= pc4_in;
        end
    end

    // Head presentation: entry at rd_ptr when valid, NOP otherwise, so stale
    // array contents never leak to decode.
    always_comb begin
        out_ins = FQ_NOP;
        out_pc4 = FQ_NOP;
        if (out_valid_s) begin
            out_ins = ins_mem_q[rd_ptr_q];
            out_pc4 = pc4_mem_q[rd_ptr_q];
        end else begin
            out_ins = FQ_NOP;
            out_pc4 = FQ_NOP;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign count     = count_q;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed stimulus, a queue-based reference model of
// the fetch queue, a per-cycle compare process, and literal spot checks.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        Clk;
    logic        Reset;
    logic [31:0] ins_in;
    logic [31:0] pc4_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc4;
    logic        out_valid;
    logic        out_ready;
    logic        Flush;
    logic [AW:0] count;

    int vectors;
    int miscompares;

    // Reference model contents, head at index 0.
    logic [31:0] m_ins [$];
    logic [31:0] m_pc4 [$];

    fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ins_in    (ins_in),
        .pc4_in    (pc4_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ins   (out_ins),
        .out_pc4   (out_pc4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Flush     (Flush),
        .count     (count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: what the queue holds after each edge, from the rules
    // (reset/flush empty it, pop the head if non-empty and accepted, append the
    // input if there was room before the edge).
    always @(posedge Clk or negedge Reset) begin
        bit do_pop;
        bit do_push;
        if (!Reset) begin
            m_ins.delete();
            m_pc4.delete();
        end else if (Flush) begin
            m_ins.delete();
            m_pc4.delete();
        end else begin
            do_pop  = (m_ins.size() != 0) && out_ready;
            do_push = in_valid && (m_ins.size() < DEPTH);
            if (do_pop) begin
                void'(m_ins.pop_front());
                void'(m_pc4.pop_front());
            end
            if (do_push) begin
                m_ins.push_back(ins_in);
                m_pc4.push_back(pc4_in);
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge Clk) begin
        logic        e_v;
        logic [31:0] e_i;
        logic [31:0] e_p;
        e_v = (m_ins.size() != 0);
        e_i = e_v ? m_ins[0] : 32'h0;
        e_p = e_v ? m_pc4[0] : 32'h0;
        chk("model_out_valid", {31'd0, out_valid}, {31'd0, e_v});
        chk("model_out_ins", out_ins, e_i);
        chk("model_out_pc4", out_pc4, e_p);
        chk("model_count", {29'd0, count}, 32'(m_ins.size()));
        chk("model_in_ready", {31'd0, in_ready}, {31'd0, (m_ins.size() < DEPTH)});
    end

    // Apply inputs now and advance to the next falling edge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc4,
                        input logic ordy, input logic fl);
        in_valid  = iv;
        ins_in    = ins;
        pc4_in    = pc4;
        out_ready = ordy;
        Flush     = fl;
        @(negedge Clk);
    endtask

    logic [31:0] fill_ins [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset     = 1'b0;
        in_valid  = 1'b0;
        ins_in    = 32'h0;
        pc4_in    = 32'h0;
        out_ready = 1'b0;
        Flush     = 1'b0;
        fill_ins[0] = 32'h2401_0001;
        fill_ins[1] = 32'h2402_0002;
        fill_ins[2] = 32'h2403_0003;
        fill_ins[3] = 32'h2404_0004;

        // Reset state.
        repeat (2) @(negedge Clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ins", out_ins, 32'h0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);

        // Latency: push into empty queue, visible one cycle later.
        in_valid = 1'b1;
        ins_in   = 32'h8C08_0000;
        pc4_in   = 32'h0000_3004;
        #1;
        chk("lat_push_cycle_ins", out_ins, 32'h0);
        chk("lat_push_cycle_valid", {31'd0, out_valid}, 32'd0);
        @(negedge Clk);
        in_valid = 1'b0;
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_ins", out_ins, 32'h8C08_0000);
        chk("lat_pc4", out_pc4, 32'h0000_3004);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("lat_drained", {29'd0, count}, 32'd0);

        // Fill: four pushes, decode stalled; fifth push ignored.
        for (int i = 0; i < 4; i++)
            step(1'b1, fill_ins[i], 32'h0000_1004 + 32'(4 * i), 1'b0, 1'b0);
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 32'hDEAD_BEEF, 32'h0000_2000, 1'b0, 1'b0);
        chk("fill_fifth_count", {29'd0, count}, 32'd4);
        chk("fill_fifth_head", out_ins, 32'h2401_0001);
        for (int i = 0; i < 4; i++) begin
            chk("fill_order", out_ins, fill_ins[i]);
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("fill_empty_valid", {31'd0, out_valid}, 32'd0);

        // Full boundary: push offered while full and popping -> pop only.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'hA000_0000 + 32'(i), 32'h0000_4000 + 32'(4 * i), 1'b0, 1'b0);
        step(1'b1, 32'h1111_1111, 32'h0000_5000, 1'b1, 1'b0);
        chk("full_pop_count", {29'd0, count}, 32'd3);
        chk("full_pop_head", out_ins, 32'hA000_0001);
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("full_drained", {29'd0, count}, 32'd0);

        // Streaming at count 2 for 10 cycles.
        step(1'b1, 32'hB000_0000, 32'h0000_6000, 1'b0, 1'b0);
        step(1'b1, 32'hB000_0001, 32'h0000_6004, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("stream_head", out_ins, 32'hB000_0000 + 32'(i));
            step(1'b1, 32'hB000_0002 + 32'(i), 32'h0000_6008 + 32'(4 * i), 1'b1, 1'b0);
            chk("stream_count", {29'd0, count}, 32'd2);
        end

        // Flush at count 3 with push and pop offered.
        step(1'b1, 32'hC000_0000, 32'h0000_7000, 1'b0, 1'b0);
        chk("flush_pre_count", {29'd0, count}, 32'd3);
        step(1'b1, 32'hBADB_AD00, 32'h0000_7004, 1'b1, 1'b1);
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, 32'h0000_0013, 32'h0000_8004, 1'b0, 1'b0);
        chk("flush_next_head", out_ins, 32'h0000_0013);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Mid-cycle reset with count 3.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hD000_0000 + 32'(i), 32'h0000_9000, 1'b0, 1'b0);
        chk("rst3_pre_count", {29'd0, count}, 32'd3);
        in_valid = 1'b0;
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_count", {29'd0, count}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        step(1'b1, 32'h0000_0055, 32'h0000_A004, 1'b0, 1'b0);
        chk("rst_first_head", out_ins, 32'h0000_0055);
        chk("rst_first_count", {29'd0, count}, 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_queue
